// File: rtl/mem_lsu.sv
// Load/store unit in front of the byte-enabled data memory: one request at a time,
// misaligned half/word accesses split into little-endian byte beats.
package mem_lsu_pkg;
  typedef enum logic [2:0] {
    MEM_DT_BYTE  = 3'd0,
    MEM_DT_HALF  = 3'd1,
    MEM_DT_WORD  = 3'd2,
    MEM_DT_UBYTE = 3'd3,
    MEM_DT_UHALF = 3'd4
  } mem_dt_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_OTHER = 2'd3
  } errno_e;
endpackage

module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  input  logic        req_we,
  input  mem_dt_e     req_dt,
  output logic        rsp_valid,
  output logic [31:0] rsp_rd,
  output logic        rsp_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wd,
  output logic        m_we,
  output mem_dt_e     m_dt,
  input  logic [31:0] m_rd,
  input  errno_e      m_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wd_q, rd_q;
  logic        we_q, err_q;
  mem_dt_e     dt_q;
  logic [2:0]  nb_q, nb_d;
  logic [1:0]  beat_q;

  logic        misaligned;
  logic        last_beat;
  logic        single;
  logic        beat_err;
  logic [31:0] rd_merge, rd_ext;

  // Beat count of the incoming request, from data type and address alignment.
  always_comb begin
    misaligned = 1'b0;
    nb_d       = 3'd1;
    case (req_dt)
      MEM_DT_HALF, MEM_DT_UHALF: begin
        misaligned = req_addr[0];
        nb_d       = misaligned ? 3'd2 : 3'd1;
      end
      MEM_DT_WORD: begin
        misaligned = (req_addr[1:0] != 2'b00);
        nb_d       = misaligned ? 3'd4 : 3'd1;
      end
      default: ;
    endcase
  end

  assign single    = (nb_q == 3'd1);
  assign last_beat = ({1'b0, beat_q} == nb_q - 3'd1);
  assign beat_err  = (m_err != ERR_NONE);

  // Reassembly: drop this beat's byte into lane k, then extend for half loads.
  always_comb begin
    rd_merge = rd_q;
    rd_merge[{beat_q, 3'b000} +: 8] = m_rd[7:0];
    case (dt_q)
      MEM_DT_HALF:  rd_ext = {{16{rd_merge[15]}}, rd_merge[15:0]};
      MEM_DT_UHALF: rd_ext = {16'h0000, rd_merge[15:0]};
      default:      rd_ext = rd_merge;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rd    = 32'h0;
    rsp_err   = 1'b0;
    m_addr    = 32'h0;
    m_wd      = 32'h0;
    m_we      = 1'b0;
    m_dt      = MEM_DT_WORD;
    case (state_q)
      S_IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst)
          state_d = (misaligned && !SPLIT_EN) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        m_we = we_q;
        if (single) begin
          m_addr = addr_q;
          m_dt   = dt_q;
          m_wd   = wd_q;
        end else begin
          m_addr = addr_q + {30'b0, beat_q};
          m_dt   = MEM_DT_UBYTE;
          m_wd   = {24'h0, wd_q[{beat_q, 3'b000} +: 8]};
        end
        if (beat_err || last_beat)
          state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rd    = rd_q;
        rsp_err   = err_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      rd_q    <= 32'h0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wd_q    <= 32'h0;
      we_q    <= 1'b0;
      dt_q    <= MEM_DT_WORD;
      nb_q    <= 3'd1;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            wd_q   <= req_wd;
            we_q   <= req_we;
            dt_q   <= req_dt;
            nb_q   <= nb_d;
            beat_q <= 2'd0;
            rd_q   <= 32'h0;
            err_q  <= misaligned && !SPLIT_EN;
          end
        end
        S_ACCESS: begin
          if (beat_err) begin
            err_q <= 1'b1;
            rd_q  <= 32'h0;
          end else begin
            if (!we_q)
              rd_q <= single ? m_rd : rd_ext;
            beat_q <= beat_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a behavioural byte memory behind the split unit,
// plus a second instance with splitting disabled to check rejection.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_ns;
  logic        req_ready, req_ready_ns;
  logic [31:0] req_addr, req_wd;
  logic        req_we;
  mem_dt_e     req_dt;
  logic        rsp_valid, rsp_valid_ns;
  logic [31:0] rsp_rd, rsp_rd_ns;
  logic        rsp_err, rsp_err_ns;
  logic [31:0] m_addr, m_wd, m_addr_ns, m_wd_ns;
  logic        m_we, m_we_ns;
  mem_dt_e     m_dt, m_dt_ns;
  logic [31:0] m_rd, m_rd_ns;
  errno_e      m_err, m_err_ns;

  logic        err_inj;
  logic        ns_we_seen;
  logic [7:0]  mem [256];

  int          checks   = 0;
  int          failures = 0;

  logic [31:0] beat_addr [8];
  logic [31:0] beat_wd   [8];
  logic [31:0] beat_dt   [8];
  logic        beat_we   [8];

  always #5 clk = ~clk;

  mem_lsu #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wd(req_wd), .req_we(req_we), .req_dt(req_dt),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_dt(m_dt),
    .m_rd(m_rd), .m_err(m_err)
  );

  mem_lsu #(.SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_ns), .req_ready(req_ready_ns),
    .req_addr(req_addr), .req_wd(req_wd), .req_we(req_we), .req_dt(req_dt),
    .rsp_valid(rsp_valid_ns), .rsp_rd(rsp_rd_ns), .rsp_err(rsp_err_ns),
    .m_addr(m_addr_ns), .m_wd(m_wd_ns), .m_we(m_we_ns), .m_dt(m_dt_ns),
    .m_rd(m_rd_ns), .m_err(m_err_ns)
  );

  assign m_rd_ns  = 32'h0;
  assign m_err_ns = ERR_NONE;
  assign m_err    = err_inj ? ERR_RANGE : ERR_NONE;

  // Memory model: 256 bytes indexed by the low address byte, async read.
  always_comb begin
    logic [7:0] a;
    logic [7:0] b0, b1, b2, b3;
    a  = m_addr[7:0];
    b0 = mem[a];
    b1 = mem[a + 8'd1];
    b2 = mem[a + 8'd2];
    b3 = mem[a + 8'd3];
    case (m_dt)
      MEM_DT_BYTE:  m_rd = {{24{b0[7]}}, b0};
      MEM_DT_UBYTE: m_rd = {24'h0, b0};
      MEM_DT_HALF:  m_rd = {{16{b1[7]}}, b1, b0};
      MEM_DT_UHALF: m_rd = {16'h0, b1, b0};
      default:      m_rd = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (m_we && !err_inj) begin
      case (m_dt)
        MEM_DT_BYTE, MEM_DT_UBYTE: mem[m_addr[7:0]] <= m_wd[7:0];
        MEM_DT_HALF, MEM_DT_UHALF: begin
          mem[m_addr[7:0]]         <= m_wd[7:0];
          mem[m_addr[7:0] + 8'd1]  <= m_wd[15:8];
        end
        default: begin
          mem[m_addr[7:0]]         <= m_wd[7:0];
          mem[m_addr[7:0] + 8'd1]  <= m_wd[15:8];
          mem[m_addr[7:0] + 8'd2]  <= m_wd[23:16];
          mem[m_addr[7:0] + 8'd3]  <= m_wd[31:24];
        end
      endcase
    end
    if (m_we_ns)
      ns_we_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request (unit assumed idle), records beats, returns the response
  // cycle relative to accept (0 if none within the budget), then waits one more cycle.
  task automatic run_req(input bit ns, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input mem_dt_e dt,
                         output int cyc, output logic [31:0] rd, output logic err,
                         output int nbeat);
    req_addr = a;
    req_wd   = wd;
    req_we   = we;
    req_dt   = dt;
    if (ns) req_valid_ns = 1'b1;
    else    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_valid_ns = 1'b0;
    cyc   = 0;
    rd    = 'x;
    err   = 1'bx;
    nbeat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (ns ? rsp_valid_ns : rsp_valid) begin
        cyc = c;
        rd  = ns ? rsp_rd_ns : rsp_rd;
        err = ns ? rsp_err_ns : rsp_err;
        break;
      end
      if (nbeat < 8) begin
        beat_addr[nbeat] = m_addr;
        beat_wd[nbeat]   = m_wd;
        beat_dt[nbeat]   = m_dt;
        beat_we[nbeat]   = m_we;
      end
      nbeat++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          cyc, nb;
    logic [31:0] rd;
    logic        err;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_valid_ns = 1'b0; err_inj = 1'b0;
    ns_we_seen = 1'b0;
    req_addr = 32'h0; req_wd = 32'h0; req_we = 1'b0; req_dt = MEM_DT_WORD;

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rd", rsp_rd, 32'h0);
    check("rst_m_we", {31'h0, m_we}, 32'h0);
    check("rst_m_dt", 32'(m_dt), 32'(MEM_DT_WORD));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_req_ready", {31'h0, req_ready}, 32'h1);

    // Aligned word store then load.
    run_req(1'b0, 32'h10, 32'h12345678, 1'b1, MEM_DT_WORD, cyc, rd, err, nb);
    check("st_w_al_cyc", 32'(cyc), 32'd2);
    check("st_w_al_dt", beat_dt[0], 32'(MEM_DT_WORD));
    check("st_w_al_rd", rd, 32'h0);
    check("st_w_al_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'h12345678);
    check("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
    run_req(1'b0, 32'h10, 32'h0, 1'b0, MEM_DT_WORD, cyc, rd, err, nb);
    check("ld_w_al_cyc", 32'(cyc), 32'd2);
    check("ld_w_al_rd", rd, 32'h12345678);
    check("ld_w_al_err", {31'h0, err}, 32'h0);

    // Misaligned word store: four byte beats at 5..8.
    run_req(1'b0, 32'h5, 32'hA1B2C3D4, 1'b1, MEM_DT_WORD, cyc, rd, err, nb);
    check("st_w_mis_cyc", 32'(cyc), 32'd5);
    check("st_w_mis_b0_addr", beat_addr[0], 32'h5);
    check("st_w_mis_b3_addr", beat_addr[3], 32'h8);
    check("st_w_mis_b0_wd", beat_wd[0], 32'h000000D4);
    check("st_w_mis_b1_wd", beat_wd[1], 32'h000000C3);
    check("st_w_mis_b2_wd", beat_wd[2], 32'h000000B2);
    check("st_w_mis_b3_wd", beat_wd[3], 32'h000000A1);
    check("st_w_mis_dt", beat_dt[1], 32'(MEM_DT_UBYTE));
    check("st_w_mis_we", {31'h0, beat_we[2]}, 32'h1);
    run_req(1'b0, 32'h5, 32'h0, 1'b0, MEM_DT_WORD, cyc, rd, err, nb);
    check("ld_w_mis_cyc", 32'(cyc), 32'd5);
    check("ld_w_mis_rd", rd, 32'hA1B2C3D4);

    run_req(1'b0, 32'h7, 32'h0, 1'b0, MEM_DT_HALF, cyc, rd, err, nb);
    check("ld_h_mis_cyc", 32'(cyc), 32'd3);
    check("ld_h_mis_rd", rd, 32'hFFFFA1B2);
    run_req(1'b0, 32'h7, 32'h0, 1'b0, MEM_DT_UHALF, cyc, rd, err, nb);
    check("ld_uh_mis_rd", rd, 32'h0000A1B2);
    run_req(1'b0, 32'h8, 32'h0, 1'b0, MEM_DT_BYTE, cyc, rd, err, nb);
    check("ld_b_cyc", 32'(cyc), 32'd2);
    check("ld_b_rd", rd, 32'hFFFFFFA1);

    // Address wrap across 0xFFFFFFFF.
    run_req(1'b0, 32'hFFFFFFFF, 32'h0000BEEF, 1'b1, MEM_DT_HALF, cyc, rd, err, nb);
    check("wrap_b0_addr", beat_addr[0], 32'hFFFFFFFF);
    check("wrap_b1_addr", beat_addr[1], 32'h00000000);
    run_req(1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, MEM_DT_UHALF, cyc, rd, err, nb);
    check("wrap_ld_rd", rd, 32'h0000BEEF);

    // Splitting disabled: misaligned store rejected without any beat.
    run_req(1'b1, 32'h6, 32'hDEADBEEF, 1'b1, MEM_DT_WORD, cyc, rd, err, nb);
    check("ns_cyc", 32'(cyc), 32'd1);
    check("ns_err", {31'h0, err}, 32'h1);
    check("ns_rd", rd, 32'h0);
    check("ns_no_we", {31'h0, ns_we_seen}, 32'h0);

    // Reset during the second beat of a misaligned word store at 0x21.
    req_addr = 32'h21; req_wd = 32'h55667788; req_we = 1'b1; req_dt = MEM_DT_WORD;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstmid_beat_addr", m_addr, 32'h22);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_m_we", {31'h0, m_we}, 32'h0);
    check("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
    check("rstmid_rsp_valid2", {31'h0, rsp_valid}, 32'h0);
    check("rstmid_mem", {mem[8'h24], mem[8'h23], mem[8'h22], mem[8'h21]}, 32'h00007788);

    // Downstream error on beat 0.
    err_inj = 1'b1;
    run_req(1'b0, 32'h10, 32'h0, 1'b0, MEM_DT_WORD, cyc, rd, err, nb);
    check("err_al_cyc", 32'(cyc), 32'd2);
    check("err_al_err", {31'h0, err}, 32'h1);
    check("err_al_rd", rd, 32'h0);
    run_req(1'b0, 32'h5, 32'h0, 1'b0, MEM_DT_WORD, cyc, rd, err, nb);
    check("err_mis_beats", 32'(nb), 32'd1);
    check("err_mis_err", {31'h0, err}, 32'h1);
    check("err_mis_rd", rd, 32'h0);
    err_inj = 1'b0;

    run_req(1'b0, 32'h5, 32'h0, 1'b0, MEM_DT_WORD, cyc, rd, err, nb);
    check("post_err_rd", rd, 32'hA1B2C3D4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of the byte-enabled data memory (`mem`). It drives that memory's addr/wd/we/dt port and consumes its rd/err outputs.
- Accepts one CPU load/store request at a time at any byte alignment.
- Aligned requests are issued as a single memory beat.
- Misaligned half/word requests are split into sequential byte beats. Read beats are reassembled little-endian and sign/zero-extended per the requested data type.
- Returns a single-cycle response pulse.

Parameters:
- SPLIT_EN, 1: 1 = split misaligned accesses into byte beats; 0 = reject them with rsp_err, issuing no memory beat.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE and not in reset.
- req_addr  in  32  byte address, any alignment.
- req_wd  in  32  store data; data is in the low bits for byte/half.
- req_we  in  1  1 = store, 0 = load.
- req_dt  in  mem_dt_e  MEM_DT_BYTE/HALF/WORD/UBYTE/UHALF.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rd  out  32  load result; 0 for stores and for errors.
- rsp_err  out  1  misaligned-rejected or downstream error.
- m_addr  out  32  to mem addr.
- m_wd  out  32  to mem wd.
- m_we  out  1  to mem we.
- m_dt  out  mem_dt_e  to mem dt.
- m_rd  in  32  from mem rd; async, valid in the same cycle as the beat.
- m_err  in  errno_e  from mem err; any nonzero encoding = error.

Behaviour:
- Clock/reset: single clock clk. Reset rst is synchronous and active-high.
- States: IDLE, ACCESS, RESP.
- Reset values: state=IDLE, rsp_valid=0, rsp_rd=0, rsp_err=0, beat counter=0, m_we=0.
- Idle memory-side outputs (any state other than ACCESS): m_we=0, m_addr=0, m_wd=0, m_dt=MEM_DT_WORD.
- IDLE: req_ready=1.
  - On req_valid, latch addr/wd/we/dt and compute the beat count NB.
  - NB=1 if aligned: BYTE/UBYTE any address, HALF/UHALF with addr[0]=0, WORD with addr[1:0]=0.
  - NB=2 for misaligned HALF/UHALF; NB=4 for misaligned WORD.
  - If misaligned and SPLIT_EN=0: go to RESP with rsp_err=1. Otherwise go to ACCESS.
- ACCESS: one beat per cycle, beat index k = 0..NB-1.
  - NB=1: m_addr=addr, m_dt=req_dt, m_wd=wd.
  - NB>1: m_addr=addr+k (32-bit wrap, so 0xFFFFFFFF+1=0x00000000), m_dt=MEM_DT_UBYTE, m_wd={24'b0, wd[8k+7:8k]}.
  - m_we=latched req_we for every beat.
  - Loads: m_rd is sampled at the posedge ending the beat.
    - NB=1: result = m_rd as returned.
    - NB>1: m_rd[7:0] is placed into result byte k.
  - After the last beat (NB>1, loads): result is sign-extended from bit 15 if dt=HALF, zero-extended if UHALF. WORD uses all 32 bits.
  - If m_err is nonzero on any beat: stop issuing beats (no further writes), go to RESP, rsp_err=1, rsp_rd=0.
  - After beat NB-1 with no error: go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, with rsp_rd/rsp_err held. Then go to IDLE.
  - There is no response backpressure.
  - rsp_valid=0, rsp_rd=0, rsp_err=0 in all other states.
- Latency: request accept at cycle 0. Beats run in cycles 1..NB. rsp_valid is high in cycle NB+1. Next accept is no earlier than cycle NB+2.
  - Rejected misaligned request: rsp_valid in cycle 1.
- Reset asserted mid-ACCESS: abort immediately, no response. Bytes already written stay written. Next cycle state=IDLE, m_we=0.
- req_valid while req_ready=0: ignored. The requester must hold the request until the handshake.

Test Plan:
- Aligned store WORD 0x12345678 @0x10, then load WORD @0x10 -> one beat each. Load rsp_rd=0x12345678, rsp_valid in cycle 2 after accept, rsp_err=0.
- Misaligned store WORD 0xA1B2C3D4 @0x05 -> 4 UBYTE beats, m_addr 5,6,7,8 with m_wd low byte D4,C3,B2,A1. Then load WORD @0x05 -> 0xA1B2C3D4 with rsp_valid in cycle 5.
- After the above, load HALF @0x07 -> 2 beats, rsp_rd=0xFFFFA1B2. Load UHALF @0x07 -> 0x0000A1B2. Load BYTE @0x08 -> 0xFFFFFFA1 in one beat.
- SPLIT_EN=0: store WORD @0x06 -> no cycle with m_we=1. rsp_valid in cycle 1 with rsp_err=1, rsp_rd=0.
- Assert rst during beat 2 of a misaligned WORD store @0x21 -> bytes @0x21,0x22 written, @0x23,0x24 unchanged. No rsp_valid. req_ready=1 the cycle after rst deasserts.
- Force m_err nonzero on beat 0 of an aligned WORD load -> rsp_err=1, rsp_rd=0, and no further beats.
